fft_frame_loader: RTL and testbench
===================================

# fft_frame_loader

Serial-to-parallel front end for the 8-point FFT datapath. Accepts one Q1.15 real sample per handshake, assembles frames of `N` samples in a two-bank ping-pong buffer, and presents each complete frame as a parallel array with a valid/ready handshake to the FFT core's `valid_i`/`x_re_i` inputs. Ping-pong banking lets a new frame fill while the previous frame is held for the consumer.

## Interface
- `N`, 8: samples per frame; power of two ≥ 2. `LOG2N` is derived from it.
- `DATA_WIDTH`, 16: sample width, Q1.15 two's complement.
- `clk_i`, input, 1: single clock; all state updates on the rising edge.
- `rst_i`, input, 1: reset, asynchronous and active-high.
- `s_valid_i`, input, 1: upstream sample valid.
- `s_data_i`, input, DATA_WIDTH: upstream sample.
- `s_ready_o`, output, 1: loader can accept a sample this cycle.
- `flush_i`, input, 1: synchronous discard of the partially filled bank.
- `frame_valid_o`, output, 1: `frame_o` holds a complete frame.
- `frame_ready_i`, input, 1: consumer accepts the frame this cycle.
- `frame_o`, output, DATA_WIDTH × [0:N-1]: parallel frame, slot 0 first.
- `overflow_o`, output, 1: sticky flag, set when `s_valid_i` is high while `s_ready_o` is low.

## Operation
- State:
  - two banks of `N` × DATA_WIDTH registers
  - `full[1:0]`
  - `wr_bank`, `wr_idx[LOG2N-1:0]`
  - `rd_bank`
- Accept: `s_valid_i && s_ready_o`. The sample is written to `bank[wr_bank][slot(wr_idx)]`, then `wr_idx` increments.
- Frame completion: accept with `wr_idx == N-1` sets `full[wr_bank]`, toggles `wr_bank`, and wraps `wr_idx` to 0.
- `s_ready_o = !full[wr_bank]`, decoded from flops only; no combinational path from any input.
- `frame_valid_o = full[rd_bank]`. `frame_o = bank[rd_bank]`, driven directly from registers.
- Consume: `frame_valid_o && frame_ready_i` clears `full[rd_bank]` and toggles `rd_bank`.
- Simultaneous completion and consume in the same cycle:
  - both take effect
  - they always act on different banks unless both banks are full, in which case `s_ready_o` is low and no completion can occur
- `flush_i`:
  - sets `wr_idx` to 0; the partial data is ignored and need not be cleared
  - leaves full banks, `rd_bank`, and `wr_bank` untouched
  - has priority over an accept in the same cycle, so the sample is dropped
- `overflow_o`:
  - set on any cycle with `s_valid_i && !s_ready_o`
  - cleared only by reset
- Frames never reorder or merge. Frame order out equals frame order in.
- Reset (`rst_i` high, asynchronous) clears all of the following:
  - `full` = 0, `wr_bank` = `rd_bank` = 0, `wr_idx` = 0
  - all bank registers = 0
  - `overflow_o` = 0
  - resulting outputs: `s_ready_o` = 1, `frame_valid_o` = 0, `frame_o` = all zero
- Reset mid-frame or mid-handshake discards everything. No frame is emitted after reset release until `N` new samples are accepted.

## Timing
- Latency: the `N`th sample is accepted at edge k, and `frame_valid_o` is high in the cycle after edge k.
- Throughput: one sample per cycle sustained, provided the consumer takes each frame within `N` cycles.
- Back-to-back frames:
  - after a consume at edge k, if the other bank is full, `frame_valid_o` stays high and `frame_o` shows the next frame after edge k
  - otherwise `frame_valid_o` drops after edge k
- Stall: `s_ready_o` falls in the cycle after both banks become full. It rises in the cycle after a consume at edge k.
- `frame_o` is stable while `frame_valid_o` is high and `frame_ready_i` is low.

## Configuration
- `FFT_BITREV_EN` defined:
  - `slot(i) = bitrev_LOG2N(i)`, so `frame_o` is in bit-reversed order as required by the decimation-in-time butterfly stage
  - for `N`=8, input sample i lands in slot 0,4,2,6,1,5,3,7 for i = 0…7
- `FFT_BITREV_EN` undefined: `slot(i) = i`, natural order. Bit reversal is then the consumer's responsibility.

## Structure
- Shared package `fft_pkg` holds:
  - `FFT_N`, `FFT_LOG2N`, `FFT_IN_WIDTH` (16)
  - `sample_t`
  - `bitrev` function
- The same package is used by the FFT core.
- One sub-module, `fft_pingpong_ctrl`, owns `full`, `wr_bank`, `rd_bank`, `wr_idx`, `s_ready_o`, and `frame_valid_o`. The top level holds the bank storage and the write decode.

## Test plan
- Reset state: assert `rst_i` mid-cycle → outputs are `s_ready_o`=1, `frame_valid_o`=0, `frame_o` all 0, `overflow_o`=0 immediately, without waiting for a clock edge.
- Single frame:
  - stimulus: feed 0x0000…0x0007 on consecutive cycles with `frame_ready_i`=0
  - response: `frame_valid_o`=1 one cycle after the 8th accept
  - with `FFT_BITREV_EN`: `frame_o` = {0,4,2,6,1,5,3,7}
  - without it: `frame_o` = {0…7}
- Back-pressure:
  - stimulus: stream 24 samples, `frame_ready_i`=0
  - response: `s_ready_o` drops after 16 accepts, and `overflow_o` sets on the 17th valid
  - then assert `frame_ready_i` for one cycle → the second frame is presented next cycle and `s_ready_o` returns high
- Simultaneous events: the 8th sample of frame B is accepted in the same cycle that frame A is consumed → frame B is valid the next cycle with no bubble and no loss.
- Flush:
  - stimulus: accept 5 samples, pulse `flush_i` together with a valid sample, then feed 8 samples 0x0100…0x0107
  - response: the emitted frame contains only 0x0100…0x0107
- Reset mid-operation: reset while one bank is full and 3 samples are pending → nothing is emitted until 8 new samples are accepted.

Source files
------------

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 8-point FFT datapath: frame size, sample width,
// the Q1.15 sample type and an index bit-reversal helper. Used by both the
// frame loader and the FFT core.
// No ports (package).
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_N        = 8;
    localparam int FFT_LOG2N    = $clog2(FFT_N);
    localparam int FFT_IN_WIDTH = 16;

    // Q1.15 two's-complement sample.
    typedef logic signed [FFT_IN_WIDTH-1:0] sample_t;

    // Reverse the low 'bits' bits of 'idx'.
    function automatic int bitrev(input int idx, input int bits);
        int r;
        r = 0;
        for (int b = 0; b < bits; b++) begin
            r = (r << 1) | ((idx >> b) & 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// fft_pingpong_ctrl
// Bank bookkeeping for the two-bank ping-pong frame buffer. Tracks which banks
// hold a complete frame, which bank is being filled and at which index, and
// which bank is presented to the consumer.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   s_valid_i, flush_i  upstream sample valid, discard of the partial bank
//   frame_ready_i       consumer takes the presented frame
//   s_ready_o           a sample can be accepted (decoded from flops only)
//   frame_valid_o       the read bank holds a complete frame
//   accept              write strobe for the sample at (wr_bank, wr_idx)
//   wr_bank, wr_idx     bank and index receiving the next sample
//   rd_bank             bank presented to the consumer
// -----------------------------------------------------------------------------
module fft_pingpong_ctrl #(
    parameter int N     = 8,
    parameter int LOG2N = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_valid_i,
    input  logic             flush_i,
    input  logic             frame_ready_i,
    output logic             s_ready_o,
    output logic             frame_valid_o,
    output logic             accept,
    output logic             wr_bank,
    output logic [LOG2N-1:0] wr_idx,
    output logic             rd_bank
);

    logic [1:0] full;
    logic [1:0] full_next;
    logic       complete;
    logic       consume;

    assign s_ready_o     = !full[wr_bank];
    assign frame_valid_o = full[rd_bank];

    // A flush wins over a sample offered in the same cycle.
    assign accept   = s_valid_i && s_ready_o && !flush_i;
    assign complete = accept && (wr_idx == LOG2N'(N - 1));
    assign consume  = frame_valid_o && frame_ready_i;

    // Completion and consume never target the same bank: a completion needs
    // the write bank empty, a consume needs the read bank full.
    always_comb begin
        // NOTE: default assignment first so every path drives full_next; no latch.
        full_next = full;
        if (consume) begin
            full_next[rd_bank] = 1'b0;
        end
        if (complete) begin
            full_next[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            full <= full_next;
            if (consume) begin
                rd_bank <= !rd_bank;
            end
            if (flush_i) begin
                wr_idx <= '0;
            end else if (accept) begin
                wr_idx <= complete ? '0 : wr_idx + 1'b1;
            end
            if (complete) begin
                wr_bank <= !wr_bank;
            end
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// -----------------------------------------------------------------------------
// fft_frame_loader
// Serial-to-parallel front end for the FFT core. Samples arrive one per
// handshake and are gathered into N-sample frames in a two-bank ping-pong
// buffer; each complete frame is presented in parallel with valid/ready.
// Configuration macro: FFT_BITREV_EN -- when defined, sample i is stored in
// slot bitrev(i) so frame_o is in bit-reversed order; otherwise natural order.
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   s_valid_i, s_data_i        upstream sample stream
//   s_ready_o                  loader can accept a sample
//   flush_i                    drop the partially filled bank
//   frame_valid_o, frame_ready_i  frame handshake
//   frame_o                    parallel frame, slot 0 first
//   overflow_o                 sticky: a sample was offered while not ready
// -----------------------------------------------------------------------------
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int N          = FFT_N,
    parameter int DATA_WIDTH = FFT_IN_WIDTH
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             s_valid_i,
    input  logic [DATA_WIDTH-1:0]            s_data_i,
    output logic                             s_ready_o,
    input  logic                             flush_i,
    output logic                             frame_valid_o,
    input  logic                             frame_ready_i,
    output logic [0:N-1][DATA_WIDTH-1:0]     frame_o,
    output logic                             overflow_o
);

    localparam int LOG2N = $clog2(N);

    logic [DATA_WIDTH-1:0] bank [0:1][0:N-1];

    logic             accept;
    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] wr_idx;
    logic [LOG2N-1:0] wr_slot;

    fft_pingpong_ctrl #(
        .N     (N),
        .LOG2N (LOG2N)
    ) u_ctrl (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .s_valid_i     (s_valid_i),
        .flush_i       (flush_i),
        .frame_ready_i (frame_ready_i),
        .s_ready_o     (s_ready_o),
        .frame_valid_o (frame_valid_o),
        .accept        (accept),
        .wr_bank       (wr_bank),
        .wr_idx        (wr_idx),
        .rd_bank       (rd_bank)
    );

`ifdef FFT_BITREV_EN
    assign wr_slot = LOG2N'(bitrev(int'(wr_idx), LOG2N));
`else
    assign wr_slot = wr_idx;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the banks feed frame_o directly, so they are reset to give an all-zero frame.
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < N; s++) begin
                    bank[b][s] <= '0;
                end
            end
        end else if (accept) begin
            bank[wr_bank][wr_slot] <= s_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (s_valid_i && !s_ready_o) begin
            overflow_o <= 1'b1;
        end
    end

    always_comb begin
        for (int s = 0; s < N; s++) begin
            frame_o[s] = bank[rd_bank][s];
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_loader
// Scoreboard bench for fft_frame_loader. A frame-level reference model turns
// accepted samples into expected frames and pushes them into a queue; a
// separate monitor compares the DUT outputs against the model every cycle and
// pops a frame on each consumer handshake.
// -----------------------------------------------------------------------------
module tb_fft_frame_loader;
    import fft_pkg::*;

    localparam int N = FFT_N;
    localparam int W = FFT_IN_WIDTH;
    localparam int L = FFT_LOG2N;

    typedef logic [0:N-1][W-1:0] frame_t;

    logic         clk_i         = 1'b0;
    logic         rst_i         = 1'b0;
    logic         s_valid_i     = 1'b0;
    logic [W-1:0] s_data_i      = '0;
    logic         flush_i       = 1'b0;
    logic         frame_ready_i = 1'b0;
    logic         s_ready_o;
    logic         frame_valid_o;
    frame_t       frame_o;
    logic         overflow_o;

    fft_frame_loader dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .s_valid_i     (s_valid_i),
        .s_data_i      (s_data_i),
        .s_ready_o     (s_ready_o),
        .flush_i       (flush_i),
        .frame_valid_o (frame_valid_o),
        .frame_ready_i (frame_ready_i),
        .frame_o       (frame_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: frames held by the loader, samples of the frame
    // being gathered, and the expected frames in output order.
    frame_t  exp_q[$];
    sample_t partial[$];
    int      held  = 0;
    bit      m_ovf = 1'b0;
    bit      m_rdy;
    bit      m_cons;
    frame_t  m_f;

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Slot that input sample number i lands in.
    function automatic int tb_slot(input int i);
`ifdef FFT_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < L; b++) begin
            if ((i & (1 << b)) != 0) r = r | (1 << (L - 1 - b));
        end
        return r;
`else
        return i;
`endif
    endfunction

    function automatic frame_t make_frame(input int base);
        frame_t f;
        for (int i = 0; i < N; i++) f[tb_slot(i)] = W'(base + i);
        return f;
    endfunction

    // Model: a frame is held from its last accepted sample until consumed;
    // samples are accepted only while fewer than two frames are held.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            m_rdy  = (held < 2);
            m_cons = (held > 0) && frame_ready_i;
            if (s_valid_i && !m_rdy) m_ovf = 1'b1;
            if (flush_i) begin
                partial.delete();
            end else if (s_valid_i && m_rdy) begin
                partial.push_back(s_data_i);
                if (partial.size() == N) begin
                    for (int i = 0; i < N; i++) m_f[tb_slot(i)] = partial[i];
                    exp_q.push_back(m_f);
                    partial.delete();
                    held++;
                end
            end
            if (m_cons) held--;
        end
    end

    // Monitor: mid-cycle comparison of DUT outputs against the model.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("s_ready", s_ready_o, held < 2);
            check("frame_valid", frame_valid_o, held > 0);
            check("overflow", overflow_o, m_ovf);
            if (frame_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got %h, expected no frame", frame_o);
                end else begin
                    check("frame_data", frame_o, exp_q[0]);
                    if (frame_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [W-1:0] d, input bit fl, input bit rd);
        s_valid_i     = v;
        s_data_i      = d;
        flush_i       = fl;
        frame_ready_i = rd;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_s_ready"}, s_ready_o, 1'b1);
        check({tag, "_frame_valid"}, frame_valid_o, 1'b0);
        check({tag, "_frame"}, frame_o, '0);
        check({tag, "_overflow"}, overflow_o, 1'b0);
    endtask

    task automatic model_clear();
        exp_q.delete();
        partial.delete();
        held  = 0;
        m_ovf = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset asserted mid-cycle: outputs must clear before any clock edge.
        #2 rst_i = 1'b1;
        #1 check_reset_state("reset");
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Single frame, consumer stalled.
        for (int i = 0; i < N; i++) cyc(1'b1, W'(i), 1'b0, 1'b0);
        s_valid_i = 1'b0;
        @(negedge clk_i);
        check("single_valid", frame_valid_o, 1'b1);
        check("single_order", frame_o, make_frame(0));
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Back-pressure: 24 offered samples, only two frames fit.
        for (int i = 0; i < 3 * N; i++) cyc(1'b1, W'(16'h0010 + i), 1'b0, 1'b0);
        s_valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_stalled", s_ready_o, 1'b0);
        check("bp_overflow", overflow_o, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk_i);
        check("bp_next_valid", frame_valid_o, 1'b1);
        check("bp_next_frame", frame_o, make_frame(16'h0018));
        check("bp_ready_back", s_ready_o, 1'b1);

        // Completion of frame B in the same cycle frame A is consumed.
        for (int i = 0; i < N - 1; i++) cyc(1'b1, W'(16'h0020 + i), 1'b0, 1'b0);
        cyc(1'b1, W'(16'h0020 + N - 1), 1'b0, 1'b1);
        s_valid_i     = 1'b0;
        frame_ready_i = 1'b0;
        @(negedge clk_i);
        check("simul_valid", frame_valid_o, 1'b1);
        check("simul_frame", frame_o, make_frame(16'h0020));
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Flush drops the partial frame and the sample offered with it.
        for (int i = 0; i < 5; i++) cyc(1'b1, W'(16'h0050 + i), 1'b0, 1'b0);
        cyc(1'b1, 16'hdead, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) cyc(1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
        s_valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_frame", frame_o, make_frame(16'h0100));
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Reset with one bank full and three samples pending.
        for (int i = 0; i < N + 3; i++) cyc(1'b1, W'(16'h0200 + i), 1'b0, 1'b0);
        s_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        model_clear();
        #1 check_reset_state("midreset");
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        for (int i = 0; i < N; i++) cyc(1'b1, W'(16'h0300 + i), 1'b0, 1'b1);
        s_valid_i     = 1'b0;
        frame_ready_i = 1'b0;
        @(negedge clk_i);
        check("post_reset_frame", frame_o, make_frame(16'h0300));
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            cyc($urandom_range(0, 99) < 70, W'($urandom),
                $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 50);
        end

        // Drain and confirm every expected frame came out.
        for (int c = 0; c < 4; c++) cyc(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk_i);
        check("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
